// File: rtl/fma16_norm_round.sv
// Normalise and round the FMA sum vector to an IEEE binary16 result through an IDLE/NORM/ROUND/DONE FSM.
// Define FMA16_NORM_FLAGS_EN to build the {overflow, underflow, inexact} flag outputs; without it flags read 0.
module fma16_norm_round #(
  parameter int VEC_SIZE = 73,
  parameter int END_BITS = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [VEC_SIZE:0] sm,
  input  logic [6:0]        se,
  input  logic              ss,
  input  logic [1:0]        rm,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [15:0]       result,
  output logic [2:0]        flags,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] NORM  = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int GUARD_IDX = VEC_SIZE - 1 - END_BITS;
  localparam int RW        = END_BITS + 9;
  localparam logic [VEC_SIZE:0] LOW_MASK = {{(VEC_SIZE + 1 - GUARD_IDX){1'b0}}, {GUARD_IDX{1'b1}}};

  localparam logic [1:0] RM_RZ  = 2'b00;
  localparam logic [1:0] RM_RNE = 2'b01;
  localparam logic [1:0] RM_RDN = 2'b10;
  localparam logic [1:0] RM_RUP = 2'b11;

  logic [1:0]        state_q, state_d;
  logic [VEC_SIZE:0] sm_q, sm_d;
  logic signed [7:0] exp_q, exp_d;
  logic              sticky_q, sticky_d;
  logic              ss_q, ss_d;
  logic [1:0]        rm_q, rm_d;
  logic              ovf_in_q, ovf_in_d;
  logic [15:0]       result_q, result_d;

  logic [END_BITS-1:0] frac;
  logic                guard;
  logic                sticky_all;
  logic [7:0]          exp_field;
  logic                inc;
  logic [RW-1:0]       rounded;
  logic                ovf;
  logic                to_inf;
  logic [15:0]         round_result;

`ifdef FMA16_NORM_FLAGS_EN
  logic [2:0] flags_q, flags_d;
  logic       inexact;
  logic       underflow;
`endif

  always_comb begin
    frac       = sm_q[VEC_SIZE-1 -: END_BITS];
    guard      = sm_q[GUARD_IDX];
    sticky_all = sticky_q | (|(sm_q & LOW_MASK));
    // An unnormalised vector at rounding time is a subnormal: exponent field 0.
    exp_field  = sm_q[VEC_SIZE] ? exp_q : 8'd0;

    inc = 1'b0;
    case (rm_q)
      RM_RZ:   inc = 1'b0;
      RM_RNE:  inc = guard & (sticky_all | frac[0]);
      RM_RDN:  inc = ss_q & (guard | sticky_all);
      RM_RUP:  inc = ~ss_q & (guard | sticky_all);
      default: inc = 1'b0;
    endcase

    rounded = {1'b0, exp_field, frac} + {{(RW-1){1'b0}}, inc};
    ovf     = ovf_in_q | (rounded[RW-1:END_BITS] >= 9'd31);
    to_inf  = (rm_q == RM_RNE) | ((rm_q == RM_RDN) & ss_q) | ((rm_q == RM_RUP) & ~ss_q);

    if (ovf) begin
      round_result = to_inf ? {ss_q, 15'h7C00} : {ss_q, 15'h7BFF};
    end else begin
      round_result = {ss_q, rounded[14:0]};
    end
  end

`ifdef FMA16_NORM_FLAGS_EN
  always_comb begin
    inexact   = guard | sticky_all;
    underflow = inexact & (exp_field == 8'd0);
  end
`endif

  always_comb begin
    state_d  = state_q;
    sm_d     = sm_q;
    exp_d    = exp_q;
    sticky_d = sticky_q;
    ss_d     = ss_q;
    rm_d     = rm_q;
    ovf_in_d = ovf_in_q;
    result_d = result_q;
`ifdef FMA16_NORM_FLAGS_EN
    flags_d  = flags_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sm_d     = sm;
          exp_d    = {se[6], se};
          sticky_d = 1'b0;
          ss_d     = ss;
          rm_d     = rm;
          ovf_in_d = ($signed(se) > 7'sd31) && (|sm);
          state_d  = NORM;
        end
      end
      NORM: begin
        if (sm_q == '0) begin
          state_d = ROUND;
        end else if (exp_q < 8'sd1) begin
          sm_d     = sm_q >> 1;
          sticky_d = sticky_q | sm_q[0];
          exp_d    = exp_q + 8'sd1;
        end else if (!sm_q[VEC_SIZE] && (exp_q > 8'sd1)) begin
          sm_d  = sm_q << 1;
          exp_d = exp_q - 8'sd1;
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        result_d = round_result;
`ifdef FMA16_NORM_FLAGS_EN
        flags_d  = ovf ? 3'b101 : {1'b0, underflow, inexact};
`endif
        state_d  = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      sm_q     <= '0;
      exp_q    <= '0;
      sticky_q <= 1'b0;
      ss_q     <= 1'b0;
      rm_q     <= 2'b00;
      ovf_in_q <= 1'b0;
      result_q <= 16'h0000;
`ifdef FMA16_NORM_FLAGS_EN
      flags_q  <= 3'b000;
`endif
    end else begin
      state_q  <= state_d;
      sm_q     <= sm_d;
      exp_q    <= exp_d;
      sticky_q <= sticky_d;
      ss_q     <= ss_d;
      rm_q     <= rm_d;
      ovf_in_q <= ovf_in_d;
      result_q <= result_d;
`ifdef FMA16_NORM_FLAGS_EN
      flags_q  <= flags_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
`ifdef FMA16_NORM_FLAGS_EN
  assign flags     = flags_q;
`else
  assign flags     = 3'b000;
`endif

endmodule

// File: tb/tb_fma16_norm_round.sv
// Randomised and directed bench for fma16_norm_round against a value-level rounding model.
module tb_fma16_norm_round;

  logic        clk;
  logic        reset_n;
  logic [73:0] sm;
  logic [6:0]  se;
  logic        ss;
  logic [1:0]  rm;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] result;
  logic [2:0]  flags;
  logic        out_valid;
  logic        out_ready;

  int n_cmp = 0;
  int n_err = 0;
  int n_txn = 0;

  fma16_norm_round dut (
    .clk(clk), .reset_n(reset_n), .sm(sm), .se(se), .ss(ss), .rm(rm),
    .in_valid(in_valid), .in_ready(in_ready), .result(result), .flags(flags),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Value-level model: place the leading one, pick the binary16 exponent, and round the
  // significand at the resulting ulp position; also predicts the number of shift cycles.
  function automatic void ref_model(input logic [73:0] smv, input logic [6:0] sev, input logic ssv,
                                    input logic [1:0] rmv, output logic [15:0] res,
                                    output logic [2:0] flg, output int shifts);
    int  se_i, p, e_true, e, u, m, q;
    bit  g, s, up, away;
    se_i = int'($signed(sev));
    if (smv == '0) begin
      res = {ssv, 15'h0}; flg = 3'b000; shifts = 0;
      return;
    end
    p = 0;
    for (int i = 0; i < 74; i++) if (smv[i]) p = i;
    e_true = se_i - (73 - p);
    e = (e_true >= 1) ? e_true : 1;
    u = e - se_i + 63;
    m = 0; g = 0; s = 0;
    for (int i = 0; i < 74; i++) begin
      if (smv[i]) begin
        if (i >= u) m += (1 << (i - u));
        else if (i == u - 1) g = 1;
        else s = 1;
      end
    end
    q = (e - 1) * 1024 + m;
    case (rmv)
      2'b01:   up = g && (s || (m % 2 == 1));
      2'b10:   up = ssv && (g || s);
      2'b11:   up = !ssv && (g || s);
      default: up = 0;
    endcase
    if (up) q += 1;
    if (se_i > 31 || q >= 31 * 1024) begin
      away = (rmv == 2'b01) || (rmv == 2'b10 && ssv) || (rmv == 2'b11 && !ssv);
      res = {ssv, away ? 15'h7C00 : 15'h7BFF};
      flg = 3'b101;
    end else begin
      res = {ssv, 15'(q)};
      flg = {1'b0, (g || s) && (e_true < 1), g || s};
    end
    if (e_true >= 1)   shifts = 73 - p;
    else if (se_i >= 1) shifts = se_i - 1;
    else               shifts = ((1 - se_i) < (p + 1)) ? (1 - se_i) : (p + 1);
  endfunction

  // Called at #1 after a rising edge with the DUT idle.
  task automatic run_txn(input logic [73:0] smv, input logic [6:0] sev, input logic ssv,
                         input logic [1:0] rmv, input logic [15:0] want_res,
                         input logic [2:0] want_flg, input int want_lat, input int hold);
    int lat;
    logic [15:0] first_res;
    logic [2:0]  exp_flg;
`ifdef FMA16_NORM_FLAGS_EN
    exp_flg = want_flg;
`else
    exp_flg = 3'b000;
`endif
    check_eq("idle_in_ready", {31'b0, in_ready}, 32'd1);
    sm = smv; se = sev; ss = ssv; rm = rmv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("latency", lat, want_lat);
    check_eq("result", {16'b0, result}, {16'b0, want_res});
    check_eq("flags", {29'b0, flags}, {29'b0, exp_flg});
    first_res = result;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check_eq("hold_result", {16'b0, result}, {16'b0, first_res});
      check_eq("hold_in_ready", {31'b0, in_ready}, 32'd0);
      check_eq("hold_out_valid", {31'b0, out_valid}, 32'd1);
    end
    // Release with in_valid high: the input must not be taken on the release edge.
    out_ready = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    check_eq("release_idle", {30'b0, out_valid, in_ready}, 32'd1);
    $display("txn %0d sm=%h se=%0d ss=%0d rm=%0d -> result=%h flags=%b lat=%0d (want %h/%b/%0d)",
             n_txn, smv, $signed(sev), ssv, rmv, first_res, flags, lat, want_res, exp_flg, want_lat);
    n_txn++;
  endtask

  task automatic run_model_txn(input logic [73:0] smv, input logic [6:0] sev, input logic ssv,
                               input logic [1:0] rmv, input int hold);
    logic [15:0] r;
    logic [2:0]  f;
    int          sh;
    ref_model(smv, sev, ssv, rmv, r, f, sh);
    run_txn(smv, sev, ssv, rmv, r, f, 2 + sh, hold);
  endtask

  initial begin
    logic [73:0] v;
    logic [73:0] one;
    int seen;
    one = 74'd1;
    reset_n = 1'b0; sm = '0; se = '0; ss = 1'b0; rm = 2'b01;
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check_eq("reset_state", {9'b0, result, flags, in_ready, out_valid, 2'b0}, {9'b0, 16'h0, 3'b0, 1'b1, 1'b0, 2'b0});
    @(posedge clk); @(posedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed values with hand-derived expectations.
    run_txn(one << 73, 7'd15, 1'b0, 2'b01, 16'h3C00, 3'b000, 2, 4);
    run_txn(one << 70, 7'd15, 1'b0, 2'b01, 16'h3000, 3'b000, 5, 0);
    v = {12'hFFF, 62'h0};
    run_txn(v, 7'd15, 1'b0, 2'b01, 16'h4000, 3'b001, 2, 0);
    run_txn(v, 7'd15, 1'b0, 2'b00, 16'h3FFF, 3'b001, 2, 0);
    run_txn(one << 73, 7'd31, 1'b0, 2'b01, 16'h7C00, 3'b101, 2, 0);
    run_txn(one << 73, 7'd31, 1'b0, 2'b00, 16'h7BFF, 3'b101, 2, 0);
    run_txn(one << 73, 7'd31, 1'b1, 2'b10, 16'hFC00, 3'b101, 2, 0);
    run_txn(one << 73, 7'd0, 1'b0, 2'b01, 16'h0200, 3'b000, 3, 0);
    run_txn('0, 7'd15, 1'b1, 2'b01, 16'h8000, 3'b000, 2, 0);

    // Reset while normalising: the operation is dropped.
    sm = one << 40; se = 7'd15; ss = 1'b0; rm = 2'b01; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check_eq("midreset_in_ready", {31'b0, in_ready}, 32'd1);
    check_eq("midreset_out_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check_eq("midreset_no_output", seen, 0);

    // Randomised operands, biased toward normal, subnormal and overflow boundaries.
    for (int t = 0; t < 300; t++) begin
      logic [6:0] sev;
      int sel;
      v = {$urandom(), $urandom(), $urandom()};
      v = v >> $urandom_range(0, 73);
      sel = $urandom_range(0, 9);
      if (sel == 0) v = '0;
      else if (sel < 4) v = v & ~((one << $urandom_range(40, 70)) - one);
      if ($urandom_range(0, 4) == 0) sev = 7'($urandom_range(0, 127));
      else sev = 7'($urandom_range(0, 60) - 20);
      run_model_txn(v, sev, 1'($urandom()), 2'($urandom()), (t % 50 == 0) ? 2 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
